// File: rtl/ysyx_25030081_core_seq_pkg.sv
// Shared types for the multi-cycle core sequencer: state/halt-cause encodings,
// widths and the registered control-output bundle.
package ysyx_25030081_core_seq_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 64;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_F_REQ  = 3'd1,
        ST_F_WAIT = 3'd2,
        ST_EXEC   = 3'd3,
        ST_M_REQ  = 3'd4,
        ST_M_WAIT = 3'd5,
        ST_WB     = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_EBREAK = 2'd1,
        CAUSE_IFETCH = 2'd2,
        CAUSE_DMEM   = 2'd3
    } halt_cause_e;

    typedef struct packed {
        logic imem_req_valid;
        logic dmem_req_valid;
        logic dmem_req_we;
        logic pc_wen;
        logic reg_wen;
        logic csr_wen;
        logic halt;
    } ctl_t;

endpackage

// File: rtl/ysyx_25030081_perf_cnt.sv
// 64-bit free-running event counter with enable; cleared only by reset.
module ysyx_25030081_perf_cnt
    import ysyx_25030081_core_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_25030081_core_seq.sv
// Multi-cycle NPC sequencer: fetch, execute, optional memory access, write-back,
// with one-shot gating of architectural writes, halt handling and perf counters.
module ysyx_25030081_core_seq
    import ysyx_25030081_core_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic             imem_rsp_err,
    input  logic [XLEN-1:0]  imem_rsp_data,
    output logic [XLEN-1:0]  inst,
    input  logic             dec_reg_wen,
    input  logic             dec_csr_wen,
    input  logic             dec_mem_ren,
    input  logic             dec_mem_wen,
    input  logic             dec_ebreak,
    output logic             dmem_req_valid,
    output logic             dmem_req_we,
    input  logic             dmem_req_ready,
    input  logic             dmem_rsp_valid,
    input  logic             dmem_rsp_err,
    input  logic [XLEN-1:0]  dmem_rsp_data,
    output logic [XLEN-1:0]  load_data,
    output logic [XLEN-1:0]  pc_init,
    output logic             pc_wen,
    output logic             reg_wen,
    output logic             csr_wen,
    output logic             halt,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] mcycle,
    output logic [CNT_W-1:0] minstret
);

    state_e           state, state_d;
    ctl_t             ctl, ctl_d;
    halt_cause_e      cause, cause_d;
    logic [XLEN-1:0]  inst_q;
    logic [XLEN-1:0]  load_q;

    // Next state plus the control outputs that will be valid in that state.
    always_comb begin
        state_d          = state;
        cause_d          = cause;
        ctl_d            = '0;
        ctl_d.dmem_req_we = ctl.dmem_req_we;
        ctl_d.halt       = ctl.halt;
        unique case (state)
            ST_IDLE:   state_d = ST_F_REQ;
            ST_F_REQ:  if (imem_req_ready) state_d = ST_F_WAIT;
            ST_F_WAIT: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_IFETCH;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (dec_ebreak) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_EBREAK;
                end else if (dec_mem_ren || dec_mem_wen) begin
                    state_d           = ST_M_REQ;
                    ctl_d.dmem_req_we = dec_mem_wen;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_M_REQ:  if (dmem_req_ready) state_d = ST_M_WAIT;
            ST_M_WAIT: begin
                if (dmem_rsp_valid) begin
                    if (dmem_rsp_err) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_DMEM;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB:     state_d = ST_F_REQ;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_HALT;
        endcase

        ctl_d.imem_req_valid = (state_d == ST_F_REQ);
        ctl_d.dmem_req_valid = (state_d == ST_M_REQ);
        // The decoder sees a stable inst from EXEC onward, so its enables are
        // sampled on the transition into WB and pulse for that one cycle.
        ctl_d.pc_wen         = (state_d == ST_WB);
        ctl_d.reg_wen        = (state_d == ST_WB) && dec_reg_wen;
        ctl_d.csr_wen        = (state_d == ST_WB) && dec_csr_wen;
        if (state_d == ST_HALT) begin
            ctl_d.halt        = 1'b1;
            ctl_d.dmem_req_we = 1'b0;
        end
    end

    // State, control outputs and the instruction / load-data latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ctl    <= '0;
            cause  <= CAUSE_NONE;
            inst_q <= NOP_INST;
            load_q <= '0;
        end else begin
            state <= state_d;
            ctl   <= ctl_d;
            cause <= cause_d;
            if (state == ST_F_WAIT && imem_rsp_valid) begin
                inst_q <= imem_rsp_data;
            end
            if (state == ST_M_WAIT && dmem_rsp_valid && !ctl.dmem_req_we) begin
                load_q <= dmem_rsp_data;
            end
        end
    end

    ysyx_25030081_perf_cnt u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != ST_HALT),
        .cnt   (mcycle)
    );

    ysyx_25030081_perf_cnt u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == ST_WB),
        .cnt   (minstret)
    );

    assign imem_req_valid = ctl.imem_req_valid;
    assign dmem_req_valid = ctl.dmem_req_valid;
    assign dmem_req_we    = ctl.dmem_req_we;
    assign pc_wen         = ctl.pc_wen;
    assign reg_wen        = ctl.reg_wen;
    assign csr_wen        = ctl.csr_wen;
    assign halt           = ctl.halt;
    assign halt_cause     = cause;
    assign inst           = inst_q;
    assign load_data      = load_q;
    assign pc_init        = RESET_PC;

    // A response may not coincide with the handshake of its own request.
    a_imem_rsp_vs_hs: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_req_valid && imem_req_ready && imem_rsp_valid));
    a_dmem_rsp_vs_hs: assert property (@(posedge clk) disable iff (!rst_n)
        !(dmem_req_valid && dmem_req_ready && dmem_rsp_valid));
    a_ren_wen_excl: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ST_EXEC) |-> !(dec_mem_ren && dec_mem_wen));

endmodule

// File: tb/tb_ysyx_25030081_core_seq.sv
// Bench for the core sequencer: per-program cycle schedule computed from the
// latency rules, open-loop bus stimulus, and per-cycle output comparison.
module tb_ysyx_25030081_core_seq;

    localparam int MAXC = 1024;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_err;
    logic [31:0] imem_rsp_data, inst;
    logic        dec_reg_wen, dec_csr_wen, dec_mem_ren, dec_mem_wen, dec_ebreak;
    logic        dmem_req_valid, dmem_req_we, dmem_req_ready, dmem_rsp_valid, dmem_rsp_err;
    logic [31:0] dmem_rsp_data, load_data, pc_init;
    logic        pc_wen, reg_wen, csr_wen, halt;
    logic [1:0]  halt_cause;
    logic [63:0] mcycle, minstret;

    always #5 clk = ~clk;

    ysyx_25030081_core_seq dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_err(imem_rsp_err),
        .imem_rsp_data(imem_rsp_data), .inst(inst),
        .dec_reg_wen(dec_reg_wen), .dec_csr_wen(dec_csr_wen),
        .dec_mem_ren(dec_mem_ren), .dec_mem_wen(dec_mem_wen), .dec_ebreak(dec_ebreak),
        .dmem_req_valid(dmem_req_valid), .dmem_req_we(dmem_req_we),
        .dmem_req_ready(dmem_req_ready), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rsp_err(dmem_rsp_err), .dmem_rsp_data(dmem_rsp_data),
        .load_data(load_data), .pc_init(pc_init), .pc_wen(pc_wen),
        .reg_wen(reg_wen), .csr_wen(csr_wen), .halt(halt), .halt_cause(halt_cause),
        .mcycle(mcycle), .minstret(minstret)
    );

    // Reference decoder (RV32 opcode classes).
    function automatic bit is_ld(input logic [31:0] w); return w[6:0] == 7'b0000011; endfunction
    function automatic bit is_st(input logic [31:0] w); return w[6:0] == 7'b0100011; endfunction
    function automatic bit is_csr(input logic [31:0] w);
        return (w[6:0] == 7'b1110011) && (w[14:12] != 3'b000);
    endfunction
    function automatic bit has_rd(input logic [31:0] w);
        case (w[6:0])
            7'b0010011, 7'b0110011, 7'b0000011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return 1'b1;
            default: return is_csr(w);
        endcase
    endfunction

    always_comb begin
        dec_reg_wen = has_rd(inst);
        dec_csr_wen = is_csr(inst);
        dec_mem_ren = is_ld(inst);
        dec_mem_wen = is_st(inst);
        dec_ebreak  = (inst == EBREAK);
    end

    typedef struct {
        logic [31:0] word;
        int          f_rdy, f_rsp;
        bit          f_err;
        int          m_rdy, m_rsp;
        bit          m_err;
        logic [31:0] rdata;
    } ins_t;

    ins_t prog[$];

    bit          e_iv[MAXC], e_dv[MAXC], e_we[MAXC], e_wechk[MAXC];
    bit          e_pc[MAXC], e_rw[MAXC], e_cw[MAXC], e_halt[MAXC];
    logic [1:0]  e_cause[MAXC];
    logic [31:0] e_inst[MAXC], e_ld[MAXC];
    logic [63:0] e_mc[MAXC], e_mi[MAXC];
    bit          d_ir[MAXC], d_iv[MAXC], d_ie[MAXC], d_dr[MAXC], d_dv[MAXC], d_de[MAXC];
    logic [31:0] d_id[MAXC], d_dd[MAXC];
    bit          s_pc[MAXC], s_rw[MAXC], s_we[MAXC], s_halt[MAXC];
    logic [1:0]  s_cause[MAXC];
    logic [31:0] s_inst[MAXC], s_ld[MAXC];
    logic [63:0] s_mc[MAXC], s_mi[MAXC];
    int          n_dv, n_iv, end_c, cyc;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic ins_t mk(input logic [31:0] w, input int fr, input int fs, input bit fe,
                                input int mr, input int ms, input bit me, input logic [31:0] rd);
        ins_t i;
        i.word = w; i.f_rdy = fr; i.f_rsp = fs; i.f_err = fe;
        i.m_rdy = mr; i.m_rsp = ms; i.m_err = me; i.rdata = rd;
        return i;
    endfunction

    // Expected per-cycle outputs from the latency rules; cycle 0 is IDLE.
    task automatic build(input bit late_rsp);
        int t, hs, r, ex, mq, mr, wb, h;
        logic [1:0] hc;
        for (int c = 0; c < MAXC; c++) begin
            e_iv[c] = 0; e_dv[c] = 0; e_we[c] = 0; e_wechk[c] = 0; e_pc[c] = 0;
            e_rw[c] = 0; e_cw[c] = 0; e_halt[c] = 0; e_cause[c] = 0;
            e_inst[c] = NOP; e_ld[c] = 0; e_mi[c] = 0;
            d_ir[c] = 0; d_iv[c] = 0; d_ie[c] = 0; d_dr[c] = 0; d_dv[c] = 0; d_de[c] = 0;
            d_id[c] = $urandom(); d_dd[c] = $urandom();
        end
        h = MAXC; hc = 2'd0; t = 1;
        foreach (prog[i]) begin
            if (t > MAXC - 60) break;
            for (int k = 0; k <= prog[i].f_rdy; k++) begin
                e_iv[t+k] = 1;
                d_dv[t+k] = 1'($urandom_range(0, 1)); d_de[t+k] = 1'($urandom_range(0, 1));
            end
            hs = t + prog[i].f_rdy;
            d_ir[hs] = 1;
            for (int k = 1; k <= prog[i].f_rsp; k++) d_dv[hs+k] = 1'($urandom_range(0, 1));
            r = hs + 1 + prog[i].f_rsp;
            d_iv[r] = 1; d_ie[r] = prog[i].f_err; d_id[r] = prog[i].word;
            for (int c = r + 1; c < MAXC; c++) e_inst[c] = prog[i].word;
            if (prog[i].f_err) begin h = r + 1; hc = 2'd2; break; end
            ex = r + 1;
            if (prog[i].word == EBREAK) begin h = ex + 1; hc = 2'd1; break; end
            if (is_ld(prog[i].word) || is_st(prog[i].word)) begin
                mq = ex + 1;
                for (int k = 0; k <= prog[i].m_rdy; k++) begin
                    e_dv[mq+k] = 1; e_wechk[mq+k] = 1; e_we[mq+k] = is_st(prog[i].word);
                    d_iv[mq+k] = 1'($urandom_range(0, 1)); d_ie[mq+k] = 1'($urandom_range(0, 1));
                end
                hs = mq + prog[i].m_rdy;
                d_dr[hs] = 1;
                for (int k = 1; k <= prog[i].m_rsp; k++) d_iv[hs+k] = 1'($urandom_range(0, 1));
                mr = hs + 1 + prog[i].m_rsp;
                d_dv[mr] = 1; d_de[mr] = prog[i].m_err; d_dd[mr] = prog[i].rdata;
                if (is_ld(prog[i].word))
                    for (int c = mr + 1; c < MAXC; c++) e_ld[c] = prog[i].rdata;
                if (prog[i].m_err) begin h = mr + 1; hc = 2'd3; break; end
                wb = mr + 1;
                if (is_st(prog[i].word)) begin e_wechk[wb] = 1; e_we[wb] = 1; end
            end else begin
                wb = ex + 1;
            end
            e_pc[wb] = 1; e_rw[wb] = has_rd(prog[i].word); e_cw[wb] = is_csr(prog[i].word);
            for (int c = wb + 1; c < MAXC; c++) e_mi[c] = e_mi[c] + 64'd1;
            t = wb + 1;
        end
        if (h < MAXC) begin
            end_c = h + 6;
            for (int c = h; c < MAXC; c++) begin
                e_halt[c] = 1; e_cause[c] = hc;
                d_ir[c] = 1'($urandom_range(0, 1)); d_iv[c] = 1'($urandom_range(0, 1));
                d_dr[c] = 1'($urandom_range(0, 1)); d_dv[c] = 1'($urandom_range(0, 1));
                d_ie[c] = 1'($urandom_range(0, 1)); d_de[c] = 1'($urandom_range(0, 1));
            end
        end else begin
            end_c = t;
            e_iv[t] = 1;
        end
        for (int c = 0; c < MAXC; c++) e_mc[c] = 64'((c < h) ? c : h);
        if (late_rsp) begin d_dv[0] = 1; d_de[0] = 1; end
    endtask

    task automatic idle_inputs();
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_err = 0; imem_rsp_data = 0;
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_err = 0; dmem_rsp_data = 0;
    endtask

    task automatic cmp(input int c);
        chk("imem_req_valid", 64'(imem_req_valid), 64'(e_iv[c]));
        chk("dmem_req_valid", 64'(dmem_req_valid), 64'(e_dv[c]));
        if (e_wechk[c]) chk("dmem_req_we", 64'(dmem_req_we), 64'(e_we[c]));
        chk("pc_wen", 64'(pc_wen), 64'(e_pc[c]));
        chk("reg_wen", 64'(reg_wen), 64'(e_rw[c]));
        chk("csr_wen", 64'(csr_wen), 64'(e_cw[c]));
        chk("halt", 64'(halt), 64'(e_halt[c]));
        chk("halt_cause", 64'(halt_cause), 64'(e_cause[c]));
        chk("inst", 64'(inst), 64'(e_inst[c]));
        chk("load_data", 64'(load_data), 64'(e_ld[c]));
        chk("mcycle", mcycle, e_mc[c]);
        chk("minstret", minstret, e_mi[c]);
        chk("pc_init", 64'(pc_init), 64'h8000_0000);
        s_pc[c] = pc_wen; s_rw[c] = reg_wen; s_we[c] = dmem_req_we; s_halt[c] = halt;
        s_cause[c] = halt_cause; s_inst[c] = inst; s_ld[c] = load_data;
        s_mc[c] = mcycle; s_mi[c] = minstret;
        n_dv += int'(dmem_req_valid); n_iv += int'(imem_req_valid);
    endtask

    // Entered at posedge+1 with rst_n low; releases reset and steps the schedule.
    task automatic run(input bit late_rsp, input int stop_at);
        build(late_rsp);
        n_dv = 0; n_iv = 0;
        rst_n = 1;
        for (int c = 0; c <= end_c; c++) begin
            if (c == stop_at) break;
            cyc = c;
            imem_req_ready = d_ir[c]; imem_rsp_valid = d_iv[c];
            imem_rsp_err = d_ie[c]; imem_rsp_data = d_id[c];
            dmem_req_ready = d_dr[c]; dmem_rsp_valid = d_dv[c];
            dmem_rsp_err = d_de[c]; dmem_rsp_data = d_dd[c];
            @(negedge clk);
            cmp(c);
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 0;
        #1;
        cyc = -1;
        chk("rst_inst", 64'(inst), 64'(NOP));
        chk("rst_load_data", 64'(load_data), 64'd0);
        chk("rst_mcycle", mcycle, 64'd0);
        chk("rst_minstret", minstret, 64'd0);
        chk("rst_imem_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_dmem_req_valid", 64'(dmem_req_valid), 64'd0);
        chk("rst_pc_wen", 64'(pc_wen), 64'd0);
        chk("rst_halt", 64'({halt, halt_cause}), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int k;
        r = $urandom();
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2: return {r[31:7], 7'b0010011};
            3:       return {r[31:7], 7'b0110011};
            4:       return {r[31:7], 7'b1100011};
            5:       return {r[31:7], 7'b0110111};
            6:       return {r[31:15], 3'b010, r[11:7], 7'b0000011};
            7:       return {r[31:7], 7'b0100011};
            8:       return {r[31:15], 3'b001, r[11:7], 7'b1110011};
            default: return {r[31:7], 7'b1101111};
        endcase
    endfunction

    initial begin
        rst_n = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;

        // addi, single-cycle memory: pc_wen in cycle 4 counting F_REQ as 1
        prog = {};
        prog.push_back(mk(32'h0010_0093, 0, 0, 0, 0, 0, 0, 0));
        run(0, -1);
        cyc = -2;
        chk("addi_pc_wen_c4", 64'(s_pc[4]), 64'd1);
        chk("addi_pc_wen_c3", 64'(s_pc[3]), 64'd0);
        chk("addi_reg_wen_c4", 64'(s_rw[4]), 64'd1);
        chk("addi_minstret", s_mi[5], 64'd1);
        reset_dut();

        // lw with 3 ready stalls and response two cycles after handshake
        prog = {};
        prog.push_back(mk(32'h0000_a103, 0, 0, 0, 3, 1, 0, 32'hDEAD_BEEF));
        run(0, -1);
        cyc = -2;
        chk("lw_dv_cycles", 64'(n_dv), 64'd4);
        chk("lw_load_data_wb", 64'(s_ld[10]), 64'hDEAD_BEEF);
        chk("lw_reg_wen_wb", 64'(s_rw[10]), 64'd1);
        reset_dut();

        // sw
        prog = {};
        prog.push_back(mk(32'h0020_a023, 0, 0, 0, 0, 0, 0, 32'h1234_5678));
        run(0, -1);
        cyc = -2;
        chk("sw_pc_wen_wb", 64'(s_pc[6]), 64'd1);
        chk("sw_reg_wen_wb", 64'(s_rw[6]), 64'd0);
        chk("sw_we_wb", 64'(s_we[6]), 64'd1);
        reset_dut();

        // ebreak
        prog = {};
        prog.push_back(mk(EBREAK, 0, 0, 0, 0, 0, 0, 0));
        run(0, -1);
        cyc = -2;
        chk("ebreak_cause", 64'(s_cause[4]), 64'd1);
        chk("ebreak_iv_cycles", 64'(n_iv), 64'd1);
        chk("ebreak_mcycle_frozen", s_mc[9], 64'd4);
        chk("ebreak_minstret", s_mi[9], 64'd0);
        reset_dut();

        // instruction fetch fault on first fetch
        prog = {};
        prog.push_back(mk(32'hCAFE_0F0F, 0, 0, 1, 0, 0, 0, 0));
        run(0, -1);
        cyc = -2;
        chk("ifault_cause", 64'(s_cause[3]), 64'd2);
        chk("ifault_inst", 64'(s_inst[3]), 64'hCAFE_0F0F);
        reset_dut();

        // load access fault
        prog = {};
        prog.push_back(mk(32'h0000_a103, 0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD));
        run(0, -1);
        cyc = -2;
        chk("dfault_cause", 64'(s_cause[6]), 64'd3);
        chk("dfault_halt", 64'(s_halt[6]), 64'd1);
        reset_dut();

        // reset during M_WAIT, stale response in the first cycle after release
        prog = {};
        prog.push_back(mk(32'h0000_a103, 0, 0, 0, 0, 5, 0, 32'h5555_AAAA));
        run(0, 7);
        reset_dut();
        prog = {};
        prog.push_back(mk(32'h0010_0093, 0, 1, 0, 0, 0, 0, 0));
        run(1, -1);
        cyc = -2;
        chk("rst_restart_minstret", s_mi[6], 64'd1);
        chk("rst_restart_halt", 64'(s_halt[6]), 64'd0);
        reset_dut();

        // randomized programs with random stalls and rare faults
        for (int run_i = 0; run_i < 6; run_i++) begin
            prog = {};
            for (int n = 0; n < 25; n++) begin
                logic [31:0] w;
                w = ($urandom_range(0, 39) == 0) ? EBREAK : rand_inst();
                prog.push_back(mk(w, $urandom_range(0, 3), $urandom_range(0, 3),
                                  ($urandom_range(0, 49) == 0),
                                  $urandom_range(0, 3), $urandom_range(0, 3),
                                  ($urandom_range(0, 39) == 0), $urandom()));
            end
            run(0, -1);
            reset_dut();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
